// File: rtl/secuenciador_motores.sv
`default_nettype none
// ============================================================================
// secuenciador_motores : runs the R, G, B dispensing motors one at a time.
// Rev 1.0
// ============================================================================
module secuenciador_motores #(
  parameter int CICLOS_UNIDAD = 33_333,
  parameter int PAUSA         = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic       cancel,
  input  logic [4:0] R,
  input  logic [4:0] G,
  input  logic [4:0] B,
  output logic       motor_R,
  output logic       motor_G,
  output logic       motor_B,
  output logic       busy,
  output logic       done,
  output logic       cancelado,
  output logic       error
);

  localparam int PRE_W = (CICLOS_UNIDAD > 1) ? $clog2(CICLOS_UNIDAD) : 1;
  localparam int PAU_W = (PAUSA > 1) ? $clog2(PAUSA) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CICLOS_UNIDAD - 1);
  localparam logic [PAU_W-1:0] PAU_MAX = PAU_W'(PAUSA - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN_R   = 3'd1,
    PAUSA_R = 3'd2,
    RUN_G   = 3'd3,
    PAUSA_G = 3'd4,
    RUN_B   = 3'd5,
    PAUSA_B = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PAU_W-1:0] pau_q, pau_d;
  logic [3:0]       lvl_q, lvl_d;
  logic [3:0]       lr_q, lr_d, lg_q, lg_d, lb_q, lb_d;
  logic             cancelado_q, cancelado_d;
  logic             error_q, error_d;
  logic             load;

  // First channel, in R-G-B order, that still has work; DONE if none.
  function automatic state_t pick(input logic use_r, input logic use_g, input logic use_b);
    if (use_r)      return RUN_R;
    else if (use_g) return RUN_G;
    else if (use_b) return RUN_B;
    else            return DONE;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pre_q       <= '0;
      pau_q       <= '0;
      lvl_q       <= '0;
      lr_q        <= '0;
      lg_q        <= '0;
      lb_q        <= '0;
      cancelado_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      pau_q       <= pau_d;
      lvl_q       <= lvl_d;
      lr_q        <= lr_d;
      lg_q        <= lg_d;
      lb_q        <= lb_d;
      cancelado_q <= cancelado_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    pau_d       = pau_q;
    lvl_d       = lvl_q;
    lr_d        = lr_q;
    lg_d        = lg_q;
    lb_d        = lb_q;
    cancelado_d = 1'b0;
    error_d     = 1'b0;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (enter && !cancel) begin
          if (R[4] | G[4] | B[4]) begin
            error_d = 1'b1;
          end else begin
            lr_d    = R[3:0];
            lg_d    = G[3:0];
            lb_d    = B[3:0];
            state_d = pick(|R[3:0], |G[3:0], |B[3:0]);
            load    = 1'b1;
          end
        end
      end
      RUN_R, RUN_G, RUN_B: begin
        // Prescaler counts one level unit; the level counter counts units.
        if (pre_q == PRE_MAX) begin
          pre_d = '0;
          if (lvl_q == 4'd1) begin
            lvl_d = '0;
            case (state_q)
              RUN_R:   state_d = PAUSA_R;
              RUN_G:   state_d = PAUSA_G;
              default: state_d = PAUSA_B;
            endcase
          end else begin
            lvl_d = lvl_q - 4'd1;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      PAUSA_R, PAUSA_G, PAUSA_B: begin
        if (pau_q == PAU_MAX) begin
          pau_d = '0;
          load  = 1'b1;
          case (state_q)
            PAUSA_R: state_d = pick(1'b0, |lg_q, |lb_q);
            PAUSA_G: state_d = pick(1'b0, 1'b0, |lb_q);
            default: state_d = DONE;
          endcase
        end else begin
          pau_d = pau_q + PAU_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      case (state_d)
        RUN_R:   lvl_d = lr_d;
        RUN_G:   lvl_d = lg_d;
        RUN_B:   lvl_d = lb_d;
        default: lvl_d = '0;
      endcase
    end

    // Abort overrides everything, including the DONE cycle.
    if (cancel && (state_q != IDLE)) begin
      state_d     = IDLE;
      pre_d       = '0;
      pau_d       = '0;
      lvl_d       = '0;
      cancelado_d = 1'b1;
    end
  end

  assign motor_R   = (state_q == RUN_R);
  assign motor_G   = (state_q == RUN_G);
  assign motor_B   = (state_q == RUN_B);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign cancelado = cancelado_q;
  assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_motores.sv
`default_nettype none
// ============================================================================
// tb_secuenciador_motores : directed + random bench against a schedule model.
// Rev 1.0
// ============================================================================
module tb_secuenciador_motores;

  localparam int CU = 4;
  localparam int P  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter = 1'b0;
  logic       cancel = 1'b0;
  logic [4:0] R = '0;
  logic [4:0] G = '0;
  logic [4:0] B = '0;
  logic       motor_R, motor_G, motor_B, busy, done, cancelado, error;

  int n_tests = 0;
  int n_fail  = 0;

  secuenciador_motores #(.CICLOS_UNIDAD(CU), .PAUSA(P)) dut (
    .clk(clk), .rst(rst), .enter(enter), .cancel(cancel),
    .R(R), .G(G), .B(B),
    .motor_R(motor_R), .motor_G(motor_G), .motor_B(motor_B),
    .busy(busy), .done(done), .cancelado(cancelado), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a sequence is a list of time windows measured from the
  // accepting edge, derived directly from the latched levels.
  int cyc = 0;
  bit act = 0;
  int start = 0;
  int total = 0;
  int lv[3];
  bit err_e = 0;
  bit canc_e = 0;

  always @(posedge clk) begin
    cyc++;
    err_e  = 0;
    canc_e = 0;
    if (rst) begin
      act = 0;
    end else if (act) begin
      if (cancel) begin
        act    = 0;
        canc_e = 1;
      end else if (cyc - 1 - start == total) begin
        act = 0;
      end
    end else if (enter && !cancel) begin
      if (R > 15 || G > 15 || B > 15) begin
        err_e = 1;
      end else begin
        act   = 1;
        start = cyc;
        lv[0] = int'(R);
        lv[1] = int'(G);
        lv[2] = int'(B);
        total = 0;
        for (int c = 0; c < 3; c++)
          if (lv[c] != 0) total += lv[c] * CU + P;
      end
    end
  end

  // Bits: {motor_R, motor_G, motor_B, busy, done, cancelado, error}
  function automatic logic [6:0] model_outs();
    logic [6:0] e;
    int o, t;
    e    = '0;
    e[1] = canc_e;
    e[0] = err_e;
    if (act) begin
      o    = cyc - start;
      e[3] = 1'b1;
      t    = 0;
      for (int c = 0; c < 3; c++) begin
        if (lv[c] != 0) begin
          if (o >= t && o < t + lv[c] * CU) e[6 - c] = 1'b1;
          t += lv[c] * CU + P;
        end
      end
      if (o == total) e[2] = 1'b1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (cyc > 0)
      check_eq($sformatf("outs@%0d", cyc),
               {25'd0, motor_R, motor_G, motor_B, busy, done, cancelado, error},
               {25'd0, model_outs()});
  end

  task automatic go(input logic [4:0] r, input logic [4:0] g, input logic [4:0] b);
    @(negedge clk);
    R = r; G = g; B = b;
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
  endtask

  // k counts negedges from the first cycle after acceptance until done.
  task automatic wait_done(input bit scramble, input int limit, output int k, output int ng);
    k  = 1;
    ng = 0;
    while (!done && k < limit) begin
      if (motor_G) ng++;
      if (scramble) begin
        enter = $urandom_range(0, 1);
        R = 5'($urandom);
        G = 5'($urandom);
        B = 5'($urandom);
      end
      @(negedge clk);
      k++;
    end
    enter = 1'b0;
  endtask

  initial begin
    int k, ng;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("reset_outs", {25'd0, motor_R, motor_G, motor_B, busy, done, cancelado, error}, 32'd0);
    repeat (3) @(negedge clk);

    go(5'd2, 5'd0, 5'd1);
    wait_done(1'b0, 400, k, ng);
    check_eq("sc1_done_lat", k, 17);
    check_eq("sc1_motorG_cycles", ng, 0);
    repeat (3) @(negedge clk);

    go(5'd15, 5'd15, 5'd15);
    wait_done(1'b0, 400, k, ng);
    check_eq("sc2_done_lat", k, 187);
    check_eq("sc2_motorG_cycles", ng, 60);
    repeat (3) @(negedge clk);

    go(5'd0, 5'd0, 5'd0);
    check_eq("sc3_done_first", {31'd0, done}, 32'd1);
    @(negedge clk);
    check_eq("sc3_busy_after", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);

    go(5'd3, 5'd3, 5'd16);
    check_eq("sc4_error", {31'd0, error}, 32'd1);
    check_eq("sc4_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);

    go(5'd5, 5'd5, 5'd5);
    repeat (24) @(negedge clk);
    check_eq("sc5_in_run_g", {31'd0, motor_G}, 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check_eq("sc5_busy", {31'd0, busy}, 32'd0);
    check_eq("sc5_cancelado", {31'd0, cancelado}, 32'd1);
    repeat (2) @(negedge clk);
    go(5'd5, 5'd5, 5'd5);
    check_eq("sc5_restart_R", {31'd0, motor_R}, 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("sc6_reset_mid", {25'd0, motor_R, motor_G, motor_B, busy, done, cancelado, error}, 32'd0);
    repeat (2) @(negedge clk);

    go(5'd2, 5'd3, 5'd1);
    wait_done(1'b1, 400, k, ng);
    check_eq("sc7_done_lat", k, 31);
    check_eq("sc7_motorG_cycles", ng, 12);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 499) == 0);
      enter  = ($urandom_range(0, 5) == 0);
      cancel = ($urandom_range(0, 149) == 0);
      R = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      G = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      B = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
    end
    @(negedge clk);
    rst = 1'b0; enter = 1'b0; cancel = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
